// File: rtl/fifo_line_reader_if.sv
// Stream bundle for fifo_line_reader: upstream FIFO pop port plus downstream pixel stream.
// Handshake: a word transfers on a rising edge where o_valid & o_ready; while o_valid & ~o_ready the producer holds o_data/o_sof/o_eol/o_eof stable. FIFO data is valid in the same cycle that fifo_rd_en is high and fifo_empty is low.
interface fifo_line_reader_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_rd_en;
  logic             o_ready;
  logic             o_valid;
  logic [WIDTH-1:0] o_data;
  logic             o_sof;
  logic             o_eol;
  logic             o_eof;

  modport master (
    input  fifo_empty, fifo_rd_data, o_ready,
    output fifo_rd_en, o_valid, o_data, o_sof, o_eol, o_eof
  );

  modport slave (
    output fifo_empty, fifo_rd_data, o_ready,
    input  fifo_rd_en, o_valid, o_data, o_sof, o_eol, o_eof
  );
endinterface

// File: rtl/fifo_line_reader.sv
// Pops one frame of H_ACT x V_ACT pixels from a FIFO into a registered valid/ready stream with sof/eol/eof.
// Optional FIFO_LINE_READER_UNDERRUN_CNT_EN adds the underrun_cnt output (stall cycles caused by an empty FIFO).
module fifo_line_reader #(
  parameter int WIDTH = 8,
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int H_GAP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  fifo_line_reader_if.master  bus,
  output logic                busy,
  output logic                frame_done,
  output logic [1:0]          o_dbg_state
`ifdef FIFO_LINE_READER_UNDERRUN_CNT_EN
  ,
  output logic [15:0]         underrun_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_GAP, S_DRAIN} state_t;

  localparam logic [11:0] COL_LAST = 12'(H_ACT - 1);
  localparam logic [11:0] ROW_LAST = 12'(V_ACT - 1);
  localparam logic [7:0]  GAP_LAST = 8'((H_GAP > 0) ? H_GAP - 1 : 0);
  localparam bit          HAS_GAP  = (H_GAP > 0);

  state_t           r_state;
  state_t           w_next;
  logic [11:0]      r_col;
  logic [11:0]      r_row;
  logic [7:0]       r_gap;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_sof;
  logic             r_eol;
  logic             r_eof;
  logic             r_frame_done;

  logic w_out_free;
  logic w_pop;
  logic w_start;
  logic w_col_last;
  logic w_row_last;
  logic w_busy;

  // The output register can take a new word when it is empty or being drained this cycle.
  assign w_out_free = ~r_valid | bus.o_ready;
  assign w_start    = (r_state == S_IDLE) & start;
  assign w_col_last = (r_col == COL_LAST);
  assign w_row_last = (r_row == ROW_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ: begin
        if (w_pop && w_col_last) begin
          if (w_row_last)   w_next = S_DRAIN;
          else if (HAS_GAP) w_next = S_GAP;
        end
      end
      S_GAP:   if (r_gap == GAP_LAST) w_next = S_READ;
      S_DRAIN: if (w_out_free) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy      = (r_state != S_IDLE);
    w_pop       = (r_state == S_READ) & ~bus.fifo_empty & w_out_free;
    o_dbg_state = r_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_pop) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 12'd1;
      end else begin
        r_col <= r_col + 12'd1;
      end
    end
  end

  // Gap counter restarts whenever the FSM is outside GAP, so GAP spans exactly H_GAP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_gap <= '0;
    else if (r_state != S_GAP) r_gap <= '0;
    else                       r_gap <= r_gap + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
    end else if (w_pop) begin
      r_valid <= 1'b1;
      r_data  <= bus.fifo_rd_data;
      r_sof   <= (r_col == 12'd0) & (r_row == 12'd0);
      r_eol   <= w_col_last;
      r_eof   <= w_col_last & w_row_last;
    end else if (bus.o_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_done <= 1'b0;
    else        r_frame_done <= (r_state == S_DRAIN) & w_out_free;
  end

`ifdef FIFO_LINE_READER_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (w_start) begin
      underrun_cnt <= '0;
    end else if ((r_state == S_READ) && bus.fifo_empty && w_out_free &&
                 (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

  assign bus.fifo_rd_en = w_pop;
  assign bus.o_valid    = r_valid;
  assign bus.o_data     = r_data;
  assign bus.o_sof      = r_sof;
  assign bus.o_eol      = r_eol;
  assign bus.o_eof      = r_eof;
  assign busy           = w_busy;
  assign frame_done     = r_frame_done;

endmodule
